msgr_arbiter: RTL and testbench
===============================

Name: msgr_arbiter

Overview:
- Shares the single per-core Messenger between NREQ local requesters, e.g. CPU pipeline, DMA engine, debug unit.
- Each requester posts a send or a poll.
- The arbiter grants one at a time in round-robin order and drives the Messenger's aq/read/selMsgr/wq side.
- It routes rwq, rqMsgr/wrq and done back to the owning requester, and holds the grant until the Messenger's done.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WDOG, 1024, busy cycles before the stall flag sets (WDOG ≥ 2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- reqValid  in  NREQ  requester i has an operation pending.
- reqRead  in  NREQ  1 = poll/receive, 0 = send.
- reqHdr  in  NREQ*14  per-requester aq[16:3] image: type[16:13], payload length[12:7], dest[6:3].
- reqWdata  in  NREQ*32  per-requester payload word.
- reqAccept  out  NREQ  one-cycle pulse when requester i is granted; the requester then holds its Hdr stable until reqDone.
- reqWready  out  NREQ  payload word consumed this cycle; the requester advances to the next word.
- reqRvalid  out  NREQ  rdata valid for requester i.
- rdata  out  32  shared read data, equal to rqMsgr.
- reqDone  out  NREQ  operation complete, one-cycle pulse.
- aq  out  14  to Messenger aq[16:3].
- read  out  1  to Messenger.
- wq  out  32  to Messenger.
- selMsgr  out  1  to Messenger.
- rwq  in  1  from Messenger.
- rqMsgr  in  32  from Messenger.
- wrq  in  1  from Messenger.
- done  in  1  from Messenger.
- stall  out  1  sticky watchdog flag.
- owner  out  3  index of current grant, for debug.

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high.
- Reset values: state IDLE, rrPtr = 0, owner = 0, stall = 0, busy counter = 0. All pulse outputs, selMsgr, read and aq are 0.
- State IDLE:
  - If any reqValid is set, pick the first set bit searching upward from rrPtr, wrapping at NREQ.
  - Register that index as owner, latch reqRead into rdReg, pulse reqAccept[owner] and go to ISSUE.
  - No reqValid: stay in IDLE.
- State ISSUE (exactly one cycle):
  - selMsgr = 1, read = rdReg, aq = reqHdr[owner].
  - If done is high this cycle (poll with MQ empty; rdata = 0 with wrq), pulse reqDone and go to IDLE.
  - Otherwise go to BUSY.
- State BUSY:
  - selMsgr = 0, read = rdReg, aq = reqHdr[owner].
  - Leave on the cycle done = 1: pulse reqDone[owner] and go to IDLE.
- rrPtr update: on every exit to IDLE, rrPtr <= owner+1, wrapping at NREQ to 0.
- Routing (combinational, all states):
  - wq = reqWdata[owner].
  - reqWready[owner] = rwq.
  - reqRvalid[owner] = wrq.
  - rdata = rqMsgr.
  - Non-owner bits are 0.
- Latency: a payload word is consumed in the same cycle rwq is high. Minimum gap between done and the next selMsgr is 2 cycles (IDLE then ISSUE); the Messenger is back in its idle state by then.
- Sends to the copier: done arrives with wrq in the same cycle (reply word). Both reqRvalid and reqDone pulse together for that requester.
- Zero-length send: done in the Messenger's sendAQ cycle. There are no reqWready pulses.
- reqValid deasserted after accept: ignored. The grant runs to done.
- reqValid from the owner while BUSY: not sampled until the next IDLE.
- Watchdog:
  - Counter clears in IDLE and increments in ISSUE/BUSY, saturating at WDOG.
  - stall sets when the counter reaches WDOG and clears only on reset.
  - The arbiter never aborts the Messenger.
- Spurious done in IDLE: ignored.
- Reset mid-operation: all state is cleared immediately. The Messenger is reset by the same reset.

Decomposition:
- Shared package msgr_pkg holds:
  - slot-type constants: Null = 7, Token = 1, Message = 8, Broadcast = 12;
  - aq field offsets: type 16:13, length 12:7, dest 6:3;
  - arbiter state encoding: IDLE/ISSUE/BUSY.
- One sub-module, rr_pick: given the request vector and pointer, returns the next index and a found bit. It is purely combinational and reusable by other ring arbiters.

Test Plan:
1. Req0 sends, length 3, dest 5 → reqAccept[0] one cycle after reqValid; aq = {type, 6'd3, 4'd5}; three reqWready[0] pulses aligned with rwq; reqDone[0] on done; selMsgr high exactly one cycle.
2. Req1 polls with MQ empty → in ISSUE, done = wrq = 1 with rdata = 0; reqRvalid[1] and reqDone[1] pulse the same cycle; back to IDLE the next cycle.
3. All four requesters assert reqValid continuously, rrPtr = 0 → grants in order 0,1,2,3,0. No requester is granted twice before the others; no overlap of ISSUE/BUSY.
4. Req2 sends length 1 to copyCore → one reqWready; no reqDone until the copier reply; then reqRvalid[2] and reqDone[2] fire together with rdata = checksum.
5. Hold done low for WDOG = 16 cycles after ISSUE → stall rises on the 16th busy cycle and stays 1 after done and later operations; clears only on reset.
6. Assert reset during BUSY of a length-5 send → the next cycle state is IDLE, all outputs 0, rrPtr = 0; a fresh request afterwards is accepted normally.

Source files
------------

// File: rtl/msgr_pkg.sv
// Shared Messenger definitions: slot types, aq[16:3] field layout and arbiter states.
package msgr_pkg;

  typedef enum logic [3:0] {
    SLOT_TOKEN     = 4'd1,
    SLOT_NULL      = 4'd7,
    SLOT_MESSAGE   = 4'd8,
    SLOT_BROADCAST = 4'd12
  } slot_type_e;

  // Bit positions within the Messenger's aq register; the arbiter carries aq[16:3].
  localparam int unsigned AQ_TYPE_HI = 16;
  localparam int unsigned AQ_TYPE_LO = 13;
  localparam int unsigned AQ_LEN_HI  = 12;
  localparam int unsigned AQ_LEN_LO  = 7;
  localparam int unsigned AQ_DEST_HI = 6;
  localparam int unsigned AQ_DEST_LO = 3;
  localparam int unsigned AQ_W       = AQ_TYPE_HI - AQ_DEST_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/msgr_arbiter_rr_pick.sv
// Round-robin search: first set request at or above ptr, wrapping at N.
module rr_pick
  import msgr_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  int unsigned  cand;
  logic [N-1:0] shifted;

  always_comb begin
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    shifted = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand    = (32'(ptr) + k) % N;
      shifted = req >> cand;
      if (!found && shifted[0]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/msgr_arbiter.sv
// Shares one Messenger among NREQ requesters; round-robin grant held until done.
module msgr_arbiter
  import msgr_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned WDOG = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      reqValid,
  input  logic [NREQ-1:0]      reqRead,
  input  logic [NREQ*AQ_W-1:0] reqHdr,
  input  logic [NREQ*32-1:0]   reqWdata,
  output logic [NREQ-1:0]      reqAccept,
  output logic [NREQ-1:0]      reqWready,
  output logic [NREQ-1:0]      reqRvalid,
  output logic [31:0]          rdata,
  output logic [NREQ-1:0]      reqDone,
  output logic [AQ_W-1:0]      aq,
  output logic                 read,
  output logic [31:0]          wq,
  output logic                 selMsgr,
  input  logic                 rwq,
  input  logic [31:0]          rqMsgr,
  input  logic                 wrq,
  input  logic                 done,
  output logic                 stall,
  output logic [2:0]           owner
);

  localparam int unsigned CW = $clog2(WDOG + 1);

  arb_state_e      state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      ptr_q, ptr_d;
  logic            rd_q, rd_d;
  logic [NREQ-1:0] accept_q, accept_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stall_q, stall_d;

  logic [2:0]      pick_idx;
  logic            pick_found;
  logic [NREQ-1:0] pick_oh;
  logic            pick_read;
  logic [AQ_W-1:0] hdr_sel;
  logic [31:0]     wdata_sel;
  logic            active;
  logic            op_done;

  rr_pick #(.N(NREQ), .IW(3)) u_pick (
    .req   (reqValid),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign active  = (state_q != ST_IDLE);
  assign op_done = active && done;

  always_comb begin
    hdr_sel   = '0;
    wdata_sel = '0;
    pick_oh   = '0;
    pick_read = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        hdr_sel   = reqHdr[i*AQ_W +: AQ_W];
        wdata_sel = reqWdata[i*32 +: 32];
      end
      if (pick_idx == 3'(i)) begin
        pick_oh[i] = 1'b1;
        pick_read  = reqRead[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    rd_d     = rd_q;
    accept_d = '0;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_found) begin
          owner_d  = pick_idx;
          rd_d     = pick_read;
          accept_d = pick_oh;
          state_d  = ST_ISSUE;
        end
      end
      default: begin
        if (cnt_q != CW'(WDOG)) cnt_d = cnt_q + CW'(1);
        // ISSUE and BUSY share the exit path: done ends the grant, otherwise wait in BUSY.
        if (done) begin
          state_d = ST_IDLE;
          ptr_d   = (32'(owner_q) == NREQ - 1) ? 3'd0 : owner_q + 3'd1;
        end else begin
          state_d = ST_BUSY;
        end
      end
    endcase
    if (cnt_d == CW'(WDOG)) stall_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      rd_q     <= 1'b0;
      accept_q <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      rd_q     <= rd_d;
      accept_q <= accept_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    reqWready = '0;
    reqRvalid = '0;
    reqDone   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        reqWready[i] = rwq;
        reqRvalid[i] = wrq;
        reqDone[i]   = op_done;
      end
    end
  end

  assign reqAccept = accept_q;
  assign selMsgr   = (state_q == ST_ISSUE);
  assign read      = active && rd_q;
  assign aq        = active ? hdr_sel : '0;
  assign wq        = wdata_sel;
  assign rdata     = rqMsgr;
  assign stall     = stall_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_msgr_arbiter.sv
// Self-checking bench for msgr_arbiter: bench plays requesters and the Messenger.
module tb_msgr_arbiter;
  import msgr_pkg::*;

  localparam int NREQ = 4;
  localparam int WDOG = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  reqValid;
  logic [NREQ-1:0]  reqRead;
  logic [NREQ*14-1:0] reqHdr;
  logic [NREQ*32-1:0] reqWdata;
  logic [NREQ-1:0]  reqAccept, reqWready, reqRvalid, reqDone;
  logic [31:0]      rdata, wq, rqMsgr;
  logic [13:0]      aq;
  logic             read, selMsgr, rwq, wrq, done, stall;
  logic [2:0]       owner;

  logic [13:0] hdr_a [NREQ];
  logic [31:0] wd_a  [NREQ];
  logic [NREQ-1:0] rd_a;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;
  bit m_stall  = 1'b0;

  always #5 clock = ~clock;

  always_comb begin
    reqHdr   = '0;
    reqWdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      reqHdr[i*14 +: 14]   = hdr_a[i];
      reqWdata[i*32 +: 32] = wd_a[i];
    end
  end
  assign reqRead = rd_a;

  msgr_arbiter #(.NREQ(NREQ), .WDOG(WDOG)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqRead(reqRead),
    .reqHdr(reqHdr), .reqWdata(reqWdata), .reqAccept(reqAccept), .reqWready(reqWready),
    .reqRvalid(reqRvalid), .rdata(rdata), .reqDone(reqDone), .aq(aq), .read(read),
    .wq(wq), .selMsgr(selMsgr), .rwq(rwq), .rqMsgr(rqMsgr), .wrq(wrq), .done(done),
    .stall(stall), .owner(owner)
  );

  // Lowest pending index at or after the pointer, else lowest pending overall.
  function automatic int model_grant(logic [NREQ-1:0] m, int p);
    for (int i = p; i < NREQ; i++) if (m[i]) return i;
    for (int i = 0; i < p; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [13:0] mk_hdr(slot_type_e t, int len, int dest);
    return {t, 6'(len), 4'(dest)};
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; reqValid = '0; rwq = 1'b0; wrq = 1'b0; done = 1'b0; rqMsgr = '0;
    @(negedge clock);
    reset = 1'b0;
    m_ptr = 0; m_stall = 1'b0;
  endtask

  // One complete grant: IDLE cycle, ISSUE, BUSY cycles, done (or reset at BUSY cycle rst_at).
  task automatic run_op(input logic [NREQ-1:0] mask, input int len, input int gap,
                        input bit reply, input bit issue_done, input logic [31:0] rword,
                        input bit drop, input int rst_at, output int gnt);
    int e, total;
    logic [NREQ-1:0] oh;
    bit adv, last;
    gnt = -1;
    @(negedge clock);
    reqValid = mask; rwq = 1'b0; wrq = 1'b0; done = 1'($urandom_range(0, 1)); rqMsgr = $urandom;
    #1;
    n_checks++;
    if ({selMsgr, read, aq, reqAccept, reqDone, reqWready, reqRvalid, stall, rdata} !==
        {1'b0, 1'b0, 14'd0, 4'd0, 4'd0, 4'd0, 4'd0, m_stall, rqMsgr}) begin
      n_fail++;
      $display("FAIL idle_outputs: got sel=%b rd=%b aq=%h acc=%b dn=%b wr=%b rv=%b st=%b want st=%b",
               selMsgr, read, aq, reqAccept, reqDone, reqWready, reqRvalid, stall, m_stall);
    end
    if (mask == '0) return;
    e  = model_grant(mask, m_ptr);
    oh = NREQ'(1) << e;

    @(negedge clock);
    if (drop) reqValid = mask & ~oh;
    done = issue_done; wrq = issue_done & reply; rwq = 1'b0;
    rqMsgr = issue_done ? rword : $urandom;
    #1;
    gnt = int'(owner);
    n_checks++;
    if ({reqAccept, owner, selMsgr, read, aq, wq} !== {oh, 3'(e), 1'b1, rd_a[e], hdr_a[e], wd_a[e]}) begin
      n_fail++;
      $display("FAIL issue_ctl: got acc=%b own=%0d sel=%b rd=%b aq=%h wq=%h want acc=%b own=%0d sel=1 rd=%b aq=%h wq=%h",
               reqAccept, owner, selMsgr, read, aq, wq, oh, e, rd_a[e], hdr_a[e], wd_a[e]);
    end
    n_checks++;
    if ({reqDone, reqRvalid, reqWready, rdata, stall} !==
        {(issue_done ? oh : 4'd0), ((issue_done & reply) ? oh : 4'd0), 4'd0, rqMsgr, m_stall}) begin
      n_fail++;
      $display("FAIL issue_hs: got dn=%b rv=%b wr=%b rdata=%h st=%b want done=%b reply=%b own=%0d st=%b",
               reqDone, reqRvalid, reqWready, rdata, stall, issue_done, reply, e, m_stall);
    end
    if (issue_done) begin
      total = 1;
    end else begin
      adv = 1'b0;
      for (int j = 0; j <= len + gap; j++) begin
        @(negedge clock);
        if (adv) wd_a[e] = $urandom;
        if (drop) reqValid = NREQ'($urandom);
        last = (j == len + gap);
        rwq = (j < len); done = last; wrq = last & reply;
        rqMsgr = last ? rword : $urandom;
        if (j == rst_at) begin reset = 1'b1; done = 1'b0; wrq = 1'b0; end
        #1;
        n_checks++;
        if ({reqAccept, owner, selMsgr, read, aq, wq} !== {4'd0, 3'(e), 1'b0, rd_a[e], hdr_a[e], wd_a[e]}) begin
          n_fail++;
          $display("FAIL busy_ctl[%0d]: got acc=%b own=%0d sel=%b rd=%b aq=%h wq=%h want own=%0d rd=%b aq=%h wq=%h",
                   j, reqAccept, owner, selMsgr, read, aq, wq, e, rd_a[e], hdr_a[e], wd_a[e]);
        end
        n_checks++;
        if ({reqWready, reqDone, reqRvalid, rdata} !==
            {(rwq ? oh : 4'd0), (done ? oh : 4'd0), (wrq ? oh : 4'd0), rqMsgr}) begin
          n_fail++;
          $display("FAIL busy_hs[%0d]: got wr=%b dn=%b rv=%b rdata=%h want rwq=%b done=%b wrq=%b own=%0d rdata=%h",
                   j, reqWready, reqDone, reqRvalid, rdata, rwq, done, wrq, e, rqMsgr);
        end
        n_checks++;
        if (stall !== (m_stall || (j + 1 >= WDOG))) begin
          n_fail++;
          $display("FAIL busy_stall[%0d]: got %b want %b", j, stall, (m_stall || (j + 1 >= WDOG)));
        end
        if (j == rst_at) return;
        adv = rwq;
      end
      total = len + gap + 2;
    end
    m_ptr = (e + 1) % NREQ;
    if (total >= WDOG) m_stall = 1'b1;
  endtask

  task automatic check_after_reset(input string tag);
    #1;
    n_checks++;
    if ({reqAccept, reqDone, reqWready, reqRvalid, selMsgr, read, aq, owner, stall} !== 36'd0) begin
      n_fail++;
      $display("FAIL %s: got acc=%b dn=%b wr=%b rv=%b sel=%b rd=%b aq=%h own=%0d st=%b want all 0",
               tag, reqAccept, reqDone, reqWready, reqRvalid, selMsgr, read, aq, owner, stall);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_after_reset("reset_state");
  endtask

  task automatic test_send();
    int g;
    hdr_a[0] = mk_hdr(SLOT_MESSAGE, 3, 5); rd_a[0] = 1'b0; wd_a[0] = $urandom;
    run_op(4'b0001, 3, 2, 1'b0, 1'b0, 32'h0, 1'b1, -1, g);
    n_checks++;
    if (g !== 0) begin n_fail++; $display("FAIL send_owner: got %0d want 0", g); end
  endtask

  task automatic test_poll_empty();
    int g;
    hdr_a[1] = mk_hdr(SLOT_NULL, 0, 0); rd_a[1] = 1'b1;
    run_op(4'b0010, 0, 0, 1'b1, 1'b1, 32'h0, 1'b1, -1, g);
    n_checks++;
    if (g !== 1) begin n_fail++; $display("FAIL poll_owner: got %0d want 1", g); end
    run_op(4'b0000, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, -1, g);
  endtask

  task automatic test_round_robin();
    int g;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      hdr_a[i] = mk_hdr(SLOT_MESSAGE, 1, i); rd_a[i] = 1'b0; wd_a[i] = $urandom;
    end
    for (int k = 0; k < 5; k++) begin
      run_op(4'b1111, 1, k % 2, 1'b0, 1'b0, 32'h0, 1'b0, -1, g);
      n_checks++;
      if (g !== exp_seq[k]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, g, exp_seq[k]);
      end
    end
  endtask

  task automatic test_copier();
    int g;
    logic [31:0] csum;
    csum = $urandom;
    hdr_a[2] = mk_hdr(SLOT_MESSAGE, 1, 0); rd_a[2] = 1'b0; wd_a[2] = $urandom;
    run_op(4'b0100, 1, 3, 1'b1, 1'b0, csum, 1'b1, -1, g);
    n_checks++;
    if (g !== 2) begin n_fail++; $display("FAIL copier_owner: got %0d want 2", g); end
  endtask

  task automatic test_zero_len();
    int g;
    hdr_a[3] = mk_hdr(SLOT_TOKEN, 0, 1); rd_a[3] = 1'b0; wd_a[3] = $urandom;
    run_op(4'b1000, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1, -1, g);
  endtask

  task automatic test_random();
    int g, len, gap;
    bit poll, empty, reply;
    logic [NREQ-1:0] mask;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        rd_a[i]  = 1'($urandom_range(0, 1));
        hdr_a[i] = mk_hdr(slot_type_e'(rd_a[i] ? SLOT_NULL : SLOT_MESSAGE), $urandom_range(0, 3), $urandom_range(0, 15));
        wd_a[i]  = $urandom;
      end
      mask  = NREQ'($urandom_range(1, 15));
      poll  = rd_a[model_grant(mask, m_ptr)];
      empty = poll && ($urandom_range(0, 1) == 1);
      len   = poll ? 0 : $urandom_range(0, 3);
      gap   = $urandom_range(0, 3);
      reply = poll ? 1'b1 : 1'($urandom_range(0, 1));
      run_op(mask, len, gap, reply, empty, empty ? 32'h0 : $urandom, 1'b1, -1, g);
    end
  endtask

  task automatic test_watchdog();
    int g;
    hdr_a[1] = mk_hdr(SLOT_MESSAGE, 2, 7); rd_a[1] = 1'b0; wd_a[1] = $urandom;
    run_op(4'b0010, 2, 20, 1'b0, 1'b0, 32'h0, 1'b1, -1, g);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_set: got %b want 1", stall); end
    run_op(4'b0001, 1, 0, 1'b0, 1'b0, 32'h0, 1'b1, -1, g);
    run_op(4'b0000, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, -1, g);
  endtask

  task automatic test_reset_mid();
    int g;
    hdr_a[2] = mk_hdr(SLOT_MESSAGE, 5, 9); rd_a[2] = 1'b0; wd_a[2] = $urandom;
    run_op(4'b0100, 5, 0, 1'b0, 1'b0, 32'h0, 1'b1, 2, g);
    @(negedge clock);
    reset = 1'b0; reqValid = '0; rwq = 1'b0; wrq = 1'b0; done = 1'b0;
    m_ptr = 0; m_stall = 1'b0;
    check_after_reset("reset_mid_state");
    hdr_a[0] = mk_hdr(SLOT_MESSAGE, 2, 3); rd_a[0] = 1'b0;
    run_op(4'b1111, 2, 1, 1'b0, 1'b0, 32'h0, 1'b1, -1, g);
    n_checks++;
    if (g !== 0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", g); end
  endtask

  initial begin
    reset = 1'b1; reqValid = '0; rwq = 1'b0; wrq = 1'b0; done = 1'b0; rqMsgr = '0; rd_a = '0;
    for (int i = 0; i < NREQ; i++) begin hdr_a[i] = '0; wd_a[i] = '0; end
    test_reset();
    test_send();
    test_poll_empty();
    test_round_robin();
    test_copier();
    test_zero_len();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
